// File: rtl/byte_writer.sv
// rtl/byte_writer.sv - rv32i store byte path: lane mask, aligned data, fault check, BRAM write.
// Optional STORE_RMW_EN: read-modify-write for BRAMs without byte enables.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef FUNC3_WIDTH
`define FUNC3_WIDTH 3
`endif

module byte_writer #(
   parameter int BRAM_ADDR_WIDTH = 10,
   parameter int READ_LATENCY    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [`DATA_WIDTH-1:0]     addr,
   input  logic [`DATA_WIDTH-1:0]     store_data,
   input  logic [`FUNC3_WIDTH-1:0]    func3,
   output logic                       resp_valid,
   output logic                       store_fault,
   output logic                       bram_en,
   output logic [3:0]                 bram_we,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
   output logic [`DATA_WIDTH-1:0]     bram_wdata,
   input  logic [`DATA_WIDTH-1:0]     bram_rdata
);

   localparam logic [`FUNC3_WIDTH-1:0] F3_BYTE      = `FUNC3_WIDTH'(0);
   localparam logic [`FUNC3_WIDTH-1:0] F3_HALF_WORD = `FUNC3_WIDTH'(1);
   localparam logic [`FUNC3_WIDTH-1:0] F3_WORD      = `FUNC3_WIDTH'(2);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RESP
`ifdef STORE_RMW_EN
      , READ
      , WAIT
`endif
   } state_t;

   state_t                     state, state_n;
   logic [1:0]                 off;
   logic [3:0]                 req_mask, mask_q;
   logic [`DATA_WIDTH-1:0]     req_data, data_q;
   logic                       req_fault, fault_q;
   logic [BRAM_ADDR_WIDTH-1:0] addr_q;
   logic                       accept;

   assign off    = addr[1:0];
   assign accept = (state == IDLE) && req_valid;

   always_comb begin
      req_mask  = 4'b0000;
      req_data  = '0;
      req_fault = 1'b0;
      case (func3)
         F3_BYTE: begin
            req_mask = 4'b0001 << off;
            req_data = {{(`DATA_WIDTH-8){1'b0}}, store_data[7:0]} << {off, 3'b000};
         end
         F3_HALF_WORD: begin
            req_mask  = 4'b0011 << off;
            req_data  = {{(`DATA_WIDTH-16){1'b0}}, store_data[15:0]} << {off, 3'b000};
            req_fault = off[0];
         end
         F3_WORD: begin
            req_mask  = 4'b1111;
            req_data  = store_data;
            req_fault = (off != 2'b00);
         end
         default: req_fault = 1'b1;
      endcase
   end

`ifdef STORE_RMW_EN
   localparam logic [7:0] WAIT_LAST = 8'(READ_LATENCY - 1);
   logic [7:0]             wait_cnt;
   logic [`DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         rdata_q  <= '0;
      end else if (state == READ) begin
         wait_cnt <= WAIT_LAST;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt - 8'd1;
         // Read data is valid on the last WAIT cycle only
         if (wait_cnt == 8'd0) rdata_q <= bram_rdata;
      end
   end
`else
   logic unused_rmw;
   assign unused_rmw = (^bram_rdata) ^ (READ_LATENCY > 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q  <= '0;
         data_q  <= '0;
         fault_q <= 1'b0;
         addr_q  <= '0;
      end else if (accept) begin
         mask_q  <= req_mask;
         data_q  <= req_data;
         fault_q <= req_fault;
         addr_q  <= addr[BRAM_ADDR_WIDTH+1:2];
      end
   end

   always_comb begin
      state_n     = state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      store_fault = 1'b0;
      bram_en     = 1'b0;
      bram_we     = 4'b0000;
      bram_addr   = addr_q;
      bram_wdata  = data_q;
`ifdef STORE_RMW_EN
      for (int i = 0; i < 4; i++)
         bram_wdata[8*i +: 8] = mask_q[i] ? data_q[8*i +: 8] : rdata_q[8*i +: 8];
`endif
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
`ifdef STORE_RMW_EN
               if (req_fault)               state_n = RESP;
               else if (req_mask == 4'hF)   state_n = WRITE;
               else                         state_n = READ;
`else
               state_n = req_fault ? RESP : WRITE;
`endif
            end
         end
`ifdef STORE_RMW_EN
         READ: begin
            bram_en = ~rst;
            state_n = WAIT;
         end
         WAIT: begin
            if (wait_cnt == 8'd0) state_n = WRITE;
         end
`endif
         WRITE: begin
            bram_en = ~rst;
`ifdef STORE_RMW_EN
            bram_we = rst ? 4'b0000 : 4'b1111;
`else
            bram_we = rst ? 4'b0000 : mask_q;
`endif
            state_n = RESP;
         end
         RESP: begin
            resp_valid  = 1'b1;
            store_fault = fault_q;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_byte_writer.sv
// tb/tb_byte_writer.sv - directed vector bench for byte_writer (default build).
module tb_byte_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [2:0]  func3;
   logic        resp_valid;
   logic        store_fault;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [9:0]  bram_addr;
   logic [31:0] bram_wdata;
   logic [31:0] bram_rdata;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  f3;
      logic        fault;
      logic [3:0]  we;
      logic [9:0]  baddr;
      logic [31:0] wdata;
   } vec_t;

   vec_t vecs[11];

   byte_writer #(.BRAM_ADDR_WIDTH(10), .READ_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .addr(addr), .store_data(store_data), .func3(func3),
      .resp_valid(resp_valid), .store_fault(store_fault),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      chk($sformatf("v%0d_ready_idle", idx), req_ready, 1);
      req_valid  = 1'b1;
      addr       = v.addr;
      store_data = v.data;
      func3      = v.f3;
      @(negedge clk);
      req_valid = 1'b0;
      if (v.fault) begin
         chk($sformatf("v%0d_fault_en", idx), bram_en, 0);
         chk($sformatf("v%0d_fault_we", idx), bram_we, 0);
         chk($sformatf("v%0d_fault_resp", idx), resp_valid, 1);
         chk($sformatf("v%0d_fault_flag", idx), store_fault, 1);
      end else begin
         chk($sformatf("v%0d_en", idx), bram_en, 1);
         chk($sformatf("v%0d_we", idx), bram_we, v.we);
         chk($sformatf("v%0d_baddr", idx), bram_addr, v.baddr);
         chk($sformatf("v%0d_wdata", idx), bram_wdata, v.wdata);
         chk($sformatf("v%0d_resp_early", idx), resp_valid, 0);
         @(negedge clk);
         chk($sformatf("v%0d_resp", idx), resp_valid, 1);
         chk($sformatf("v%0d_flag", idx), store_fault, 0);
         chk($sformatf("v%0d_we_off", idx), bram_we, 0);
         chk($sformatf("v%0d_ready_busy", idx), req_ready, 0);
      end
      @(negedge clk);
      chk($sformatf("v%0d_resp_done", idx), resp_valid, 0);
      chk($sformatf("v%0d_ready_back", idx), req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{32'h0000_0103, 32'hDEAD_BEEF, 3'b000, 1'b0, 4'b1000, 10'h040, 32'hEF00_0000};
      vecs[1]  = '{32'h0000_0002, 32'h1234_5678, 3'b001, 1'b0, 4'b1100, 10'h000, 32'h5678_0000};
      vecs[2]  = '{32'h0000_0008, 32'hCAFE_F00D, 3'b010, 1'b0, 4'b1111, 10'h002, 32'hCAFE_F00D};
      vecs[3]  = '{32'h0000_0001, 32'h1234_5678, 3'b001, 1'b1, 4'b0000, 10'h000, 32'h0};
      vecs[4]  = '{32'h0000_0006, 32'h1234_5678, 3'b010, 1'b1, 4'b0000, 10'h000, 32'h0};
      vecs[5]  = '{32'h0000_0000, 32'h1234_5678, 3'b011, 1'b1, 4'b0000, 10'h000, 32'h0};
      vecs[6]  = '{32'h0000_0000, 32'h0000_00A5, 3'b000, 1'b0, 4'b0001, 10'h000, 32'h0000_00A5};
      vecs[7]  = '{32'h0000_0000, 32'hFFFF_1234, 3'b001, 1'b0, 4'b0011, 10'h000, 32'h0000_1234};
      vecs[8]  = '{32'h0000_1002, 32'hFFFF_FF77, 3'b000, 1'b0, 4'b0100, 10'h000, 32'h0077_0000};
      vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0001, 3'b010, 1'b0, 4'b1111, 10'h3FF, 32'h0000_0001};
      vecs[10] = '{32'h0000_0000, 32'h0000_0001, 3'b111, 1'b1, 4'b0000, 10'h000, 32'h0};

      rst        = 1'b1;
      req_valid  = 1'b0;
      addr       = '0;
      store_data = '0;
      func3      = '0;
      bram_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_resp", resp_valid, 0);
      chk("rst_fault", store_fault, 0);
      chk("rst_en", bram_en, 0);
      chk("rst_we", bram_we, 0);
      chk("rst_baddr", bram_addr, 0);
      chk("rst_wdata", bram_wdata, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Back-to-back: req_valid held high for three sb stores to 0x10..0x12
      @(negedge clk);
      req_valid  = 1'b1;
      func3      = 3'b000;
      addr       = 32'h10;
      store_data = 32'h1;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("b2b_ready_%0d", k), req_ready, (k % 3 == 0) ? 1 : 0);
         chk($sformatf("b2b_resp_%0d", k), resp_valid, (k % 3 == 2) ? 1 : 0);
         if (k % 3 == 1) begin
            chk($sformatf("b2b_we_%0d", k), bram_we, 32'(4'b0001 << (k / 3)));
            chk($sformatf("b2b_wdata_%0d", k), bram_wdata, 32'((k / 3) + 1) << (8 * (k / 3)));
            addr       = 32'h10 + 32'((k / 3) + 1);
            store_data = 32'((k / 3) + 2);
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_ready_end", req_ready, 1);
      chk("b2b_resp_end", resp_valid, 0);

      // Reset asserted during the WRITE cycle of sb addr=0x4
      @(negedge clk);
      req_valid  = 1'b1;
      addr       = 32'h4;
      store_data = 32'h55;
      func3      = 3'b000;
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b1;
      #1;
      chk("rstmid_we", bram_we, 0);
      chk("rstmid_en", bram_en, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_ready", req_ready, 1);
      chk("rstmid_resp", resp_valid, 0);
      @(negedge clk);
      chk("rstmid_resp_late", resp_valid, 0);
      run_vec(vecs[0], 20);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
